// File: rtl/div64_result_if.sv
// ---------------------------------------------------------------------------
// div64_result_if
// Handshake bundle between divider post-processing, the result stage and
// writeback.
//   flush                        pipeline kill toward the result stage
//   in_valid / in_ready          operand handshake (accept = valid & ready)
//   in_q, in_rem                 unsigned quotient / remainder magnitudes
//   in_op, in_word               funct3[1:0] op select, W (32-bit) variant
//   in_neg_q, in_neg_rem         sign fix-up requests
//   in_div_zero, in_overflow     override conditions
//   in_dividend, in_tag          original dividend, destination tag
//   out_valid / out_ready        result handshake (pop = valid & ready)
//   out_data, out_tag            head-of-buffer result and its tag
// Modports: slave = result stage, master = producer/consumer side.
// ---------------------------------------------------------------------------
interface div64_result_if #(
    parameter int TAG_W = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_q;
    logic [63:0]      in_rem;
    logic [1:0]       in_op;
    logic             in_word;
    logic             in_neg_q;
    logic             in_neg_rem;
    logic             in_div_zero;
    logic             in_overflow;
    logic [63:0]      in_dividend;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_data;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  flush, in_valid, in_q, in_rem, in_op, in_word, in_neg_q,
               in_neg_rem, in_div_zero, in_overflow, in_dividend, in_tag,
               out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

    modport master (
        output flush, in_valid, in_q, in_rem, in_op, in_word, in_neg_q,
               in_neg_rem, in_div_zero, in_overflow, in_dividend, in_tag,
               out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/div64_result_stage.sv
// ---------------------------------------------------------------------------
// div64_result_stage
// Final stage of the 64-bit radix-4 divider. Applies RISC-V sign fix-up, op
// select, divide-by-zero / overflow overrides and W sign-extension, then holds
// results in a 2-entry in-order output buffer toward writeback. Outputs come
// straight from registers, so there is no combinational in_* -> out_* path.
// Ports:
//   clk   clock
//   rst   synchronous reset, active-high (drops all entries like flush)
//   bus   div64_result_if.slave (flush, in_* handshake, out_* handshake)
// Configuration macro:
//   DIV_RES_PIPE_EN  when defined, the result is registered in one extra
//                    pending stage before the buffer write (latency 2);
//                    otherwise the compute feeds the buffer directly
//                    (latency 1).
// ---------------------------------------------------------------------------
module div64_result_stage #(
    parameter int TAG_W = 5
) (
    input logic            clk,
    input logic            rst,
    div64_result_if.slave  bus
);

    function automatic logic [63:0] sext_word(input logic [63:0] x);
        return {{32{x[31]}}, x[31:0]};
    endfunction

    // op[1] selects remainder; overrides take priority over the negated value
    function automatic logic [63:0] compute_result(
        input logic [63:0] q,
        input logic [63:0] rem,
        input logic [1:0]  op,
        input logic        word,
        input logic        neg_q,
        input logic        neg_rem,
        input logic        div_zero,
        input logic        overflow,
        input logic [63:0] dividend
    );
        logic [63:0] mag;
        logic        neg;
        logic [63:0] v;
        mag = op[1] ? rem : q;
        neg = op[1] ? neg_rem : neg_q;
        v   = neg ? (~mag + 64'd1) : mag;
        if (div_zero) begin
            v = op[1] ? dividend : {64{1'b1}};
        end else if (overflow) begin
            v = op[1] ? 64'd0 : dividend;
        end else begin
            v = v;
        end
        return word ? sext_word(v) : v;
    endfunction

    logic [1:0]       count_r;
    logic [1:0]       count_nxt_s;
    logic             out_valid_r;
    logic [63:0]      data0_r, data1_r;
    logic [TAG_W-1:0] tag0_r, tag1_r;

    logic             in_ready_s;
    logic             accept_s;
    logic             pop_s;
    logic [63:0]      result_s;
    logic             pending_s;
    logic             wr_en_s;
    logic [63:0]      wr_data_s;
    logic [TAG_W-1:0] wr_tag_s;

    // Credit check uses registered state only; buffered plus in-flight < 2
    always_comb begin
        in_ready_s = (({1'b0, count_r} + {2'b00, pending_s}) < 3'd2);
        accept_s   = bus.in_valid & in_ready_s;
        pop_s      = out_valid_r & bus.out_ready;
        result_s   = compute_result(bus.in_q, bus.in_rem, bus.in_op, bus.in_word,
                                    bus.in_neg_q, bus.in_neg_rem, bus.in_div_zero,
                                    bus.in_overflow, bus.in_dividend);
    end

`ifdef DIV_RES_PIPE_EN
    logic             pend_valid_r;
    logic [63:0]      pend_data_r;
    logic [TAG_W-1:0] pend_tag_r;

    // Pending compute stage; flush/reset kill the in-flight result
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            pend_valid_r <= 1'b0;
            pend_data_r  <= 64'd0;
            pend_tag_r   <= '0;
        end else begin
            pend_valid_r <= accept_s;
            if (accept_s) begin
                pend_data_r <= result_s;
                pend_tag_r  <= bus.in_tag;
            end else begin
                pend_data_r <= pend_data_r;
                pend_tag_r  <= pend_tag_r;
            end
        end
    end

    // Buffer write port is fed from the pending stage
    always_comb begin
        pending_s = pend_valid_r;
        wr_en_s   = pend_valid_r;
        wr_data_s = pend_data_r;
        wr_tag_s  = pend_tag_r;
    end
`else
    // Buffer write port is fed directly by the compute
    always_comb begin
        pending_s = 1'b0;
        wr_en_s   = accept_s;
        wr_data_s = result_s;
        wr_tag_s  = bus.in_tag;
    end
`endif

    // Next occupancy; a write never targets a full buffer unless it also pops
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_en_s, pop_s})
            2'b10:   count_nxt_s = (count_r == 2'd2) ? count_r : count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase
    end

    // Shift-style 2-entry buffer: entry 0 is always the head
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r     <= 2'd0;
            out_valid_r <= 1'b0;
            data0_r     <= 64'd0;
            data1_r     <= 64'd0;
            tag0_r      <= '0;
            tag1_r      <= '0;
        end else if (bus.flush) begin
            count_r     <= 2'd0;
            out_valid_r <= 1'b0;
        end else begin
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != 2'd0);
            case ({wr_en_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        data0_r <= wr_data_s;
                        tag0_r  <= wr_tag_s;
                    end else if (count_r == 2'd1) begin
                        data1_r <= wr_data_s;
                        tag1_r  <= wr_tag_s;
                    end else begin
                        data1_r <= data1_r;
                    end
                end
                2'b01: begin
                    data0_r <= data1_r;
                    tag0_r  <= tag1_r;
                end
                2'b11: begin
                    if (count_r == 2'd2) begin
                        data0_r <= data1_r;
                        tag0_r  <= tag1_r;
                        data1_r <= wr_data_s;
                        tag1_r  <= wr_tag_s;
                    end else begin
                        data0_r <= wr_data_s;
                        tag0_r  <= wr_tag_s;
                    end
                end
                default: begin
                    data0_r <= data0_r;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = data0_r;
    assign bus.out_tag   = tag0_r;

endmodule

// File: tb/tb_div64_result_stage.sv
module tb_div64_result_stage;

`ifdef DIV_RES_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [63:0] data;
        logic [4:0]  tag;
        int          avail;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   chk_en = 1'b0;
    exp_t mq[$];

    div64_result_if #(.TAG_W(5)) bus ();

    div64_result_stage #(.TAG_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Architectural result from the rules, using plain signed arithmetic
    function automatic logic [63:0] ref_result(
        input logic [63:0] q, input logic [63:0] rem, input logic [1:0] op,
        input logic word, input logic nq, input logic nr, input logic dz,
        input logic ovf, input logic [63:0] dividend);
        logic [63:0]        v;
        logic signed [31:0] lo;
        v = op[1] ? rem : q;
        if (op[1] ? nr : nq) v = -v;
        if (dz)       v = op[1] ? dividend : 64'hFFFF_FFFF_FFFF_FFFF;
        else if (ovf) v = op[1] ? 64'd0 : dividend;
        if (word) begin
            lo = v[31:0];
            v  = 64'(lo);
        end
        return v;
    endfunction

    // Reference model: queue of results in flight, each visible from its cycle
    always @(posedge clk) begin
        bit pop;
        bit acc;
        if (rst || bus.flush) begin
            mq.delete();
        end else begin
            pop = bus.out_ready && mq.size() > 0 && mq[0].avail <= cyc;
            acc = bus.in_valid && mq.size() < 2;
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back('{ref_result(bus.in_q, bus.in_rem, bus.in_op, bus.in_word,
                                               bus.in_neg_q, bus.in_neg_rem, bus.in_div_zero,
                                               bus.in_overflow, bus.in_dividend),
                                    bus.in_tag, cyc + LAT});
        end
        cyc++;
    end

    // Compare process: DUT outputs against the model every cycle
    always @(negedge clk) begin
        bit ev;
        if (chk_en) begin
            ev = mq.size() > 0 && mq[0].avail <= cyc;
            chk("in_ready", {63'd0, bus.in_ready}, {63'd0, mq.size() < 2});
            chk("out_valid", {63'd0, bus.out_valid}, {63'd0, ev});
            if (ev) begin
                chk("out_data", bus.out_data, mq[0].data);
                chk("out_tag", {59'd0, bus.out_tag}, {59'd0, mq[0].tag});
            end
        end
    end

    task automatic idle_inputs();
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_q = 64'd0; bus.in_rem = 64'd0;
        bus.in_op = 2'd0; bus.in_word = 1'b0; bus.in_neg_q = 1'b0; bus.in_neg_rem = 1'b0;
        bus.in_div_zero = 1'b0; bus.in_overflow = 1'b0; bus.in_dividend = 64'd0;
        bus.in_tag = 5'd0; bus.out_ready = 1'b1;
    endtask

    // One directed op with a hand-computed literal and latency check
    task automatic send_check(input string name, input logic [1:0] op, input logic word,
                              input logic [63:0] q, input logic [63:0] rem,
                              input logic nq, input logic nr, input logic dz, input logic ovf,
                              input logic [63:0] dividend, input logic [63:0] exp);
        bus.in_valid = 1'b1; bus.in_op = op; bus.in_word = word; bus.in_q = q;
        bus.in_rem = rem; bus.in_neg_q = nq; bus.in_neg_rem = nr; bus.in_div_zero = dz;
        bus.in_overflow = ovf; bus.in_dividend = dividend; bus.in_tag = 5'd9;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        chk({name, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
        chk(name, bus.out_data, exp);
    endtask

    initial begin
        int nexp;
        bit acc;
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_out_tag", {59'd0, bus.out_tag}, 64'd0);

        send_check("divu", 2'b01, 1'b0, 64'd7, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'h7);
        send_check("remu", 2'b11, 1'b0, 64'd7, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'h3);
        send_check("div_neg", 2'b00, 1'b0, 64'd5, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0,
                   64'hFFFF_FFFF_FFFF_FFFB);
        send_check("rem_neg", 2'b10, 1'b0, 64'd0, 64'd2, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0,
                   64'hFFFF_FFFF_FFFF_FFFE);
        send_check("div_dz", 2'b00, 1'b0, 64'd3, 64'd1, 1'b1, 1'b0, 1'b1, 1'b0, 64'd12,
                   64'hFFFF_FFFF_FFFF_FFFF);
        send_check("remw_dz", 2'b10, 1'b1, 64'd3, 64'd1, 1'b0, 1'b1, 1'b1, 1'b0,
                   64'h0000_0000_8000_0001, 64'hFFFF_FFFF_8000_0001);
        send_check("div_ovf", 2'b00, 1'b0, 64'd1, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1,
                   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        send_check("rem_ovf", 2'b10, 1'b0, 64'd1, 64'd5, 1'b0, 1'b1, 1'b0, 1'b1,
                   64'h8000_0000_0000_0000, 64'h0);
        send_check("divw_ovf", 2'b00, 1'b1, 64'd1, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1,
                   64'h1234_5678_8000_0000, 64'hFFFF_FFFF_8000_0000);

        // Back-pressure: tags 1,2,3 with writeback stalled, then drain in order
        @(negedge clk);
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_op = 2'b01; bus.in_tag = 5'd1;
        @(posedge clk); #1 bus.in_tag = 5'd2;
        @(posedge clk); #1 bus.in_tag = 5'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("full_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("full_out_valid", {63'd0, bus.out_valid}, 64'd1);
        bus.out_ready = 1'b1;
        nexp = 1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                if (nexp <= 3) chk("pop_order", {59'd0, bus.out_tag}, 64'(nexp));
                nexp++;
            end
            @(posedge clk); #1;
            if (acc) bus.in_valid = 1'b0;
        end
        chk("pop_count", 64'(nexp), 64'd4);

        // Flush with two entries buffered and a concurrent in_valid
        @(negedge clk);
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_tag = 5'd4;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("pre_flush_ready", {63'd0, bus.in_ready}, 64'd0);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
            chk("flush_in_ready", {63'd0, bus.in_ready}, 64'd1);
        end

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            bus.in_valid    = ($urandom_range(0, 3) != 0);
            bus.out_ready   = ($urandom_range(0, 2) != 0);
            bus.flush       = ($urandom_range(0, 40) == 0);
            rst             = ($urandom_range(0, 300) == 0);
            bus.in_q        = {$urandom, $urandom};
            bus.in_rem      = {$urandom, $urandom};
            bus.in_op       = 2'($urandom_range(0, 3));
            bus.in_word     = 1'($urandom_range(0, 1));
            bus.in_neg_q    = 1'($urandom_range(0, 1));
            bus.in_neg_rem  = 1'($urandom_range(0, 1));
            bus.in_div_zero = ($urandom_range(0, 7) == 0);
            bus.in_overflow = (bus.in_op[0] == 1'b0) && ($urandom_range(0, 7) == 0);
            bus.in_dividend = {$urandom, $urandom};
            bus.in_tag      = 5'($urandom_range(0, 31));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        repeat (5) @(posedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
